// File: rtl/bkp_pkg.sv
// Shared definitions for the BK system port configuration generator and its companions.
package bkp_pkg;

  typedef enum logic [1:0] {
    BKP_IDLE = 2'd0,
    BKP_RUN  = 2'd1,
    BKP_DONE = 2'd2
  } bkp_state_t;

  localparam logic [1:0] BKP_MODE_IDX   = 2'd0;
  localparam logic [1:0] BKP_MODE_INV   = 2'd1;
  localparam logic [1:0] BKP_MODE_LFSR  = 2'd2;
  localparam logic [1:0] BKP_MODE_CONST = 2'd3;

  localparam logic [31:0] BKP_LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] BKP_LFSR_SEED = 32'hACE1_ACE1;

endpackage

// File: rtl/bkp_lfsr.sv
// Galois LFSR (right shift, tap mask applied when the outgoing bit is 1) with load and advance enables.
module bkp_lfsr
  import bkp_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(BKP_LFSR_SEED),
  parameter logic [DATA_W-1:0] POLY   = DATA_W'(BKP_LFSR_POLY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  output logic [DATA_W-1:0] lfsr_q,
  output logic [DATA_W-1:0] lfsr_nxt
);

  always_comb begin
    lfsr_nxt = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_nxt = lfsr_nxt ^ POLY;
  end

  always_ff @(posedge clk) begin
    if (rst || load) lfsr_q <= SEED;
    else if (adv)    lfsr_q <= lfsr_nxt;
  end

endmodule

// File: rtl/bkp_cfg_gen.sv
// BkpCfg index/value strobe generator: programmable pass length, fixed gap, loop,
// back-pressure and selectable value patterns.
module bkp_cfg_gen
  import bkp_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int unsigned       INDEX_MAX   = 4500,
  parameter logic [DATA_W-1:0] INDEX_BASE  = DATA_W'(1),
  parameter int                GAP         = 10,
  parameter logic [DATA_W-1:0] CONST_VALUE = '0,
  parameter logic [DATA_W-1:0] LFSR_SEED   = DATA_W'(BKP_LFSR_SEED),
  parameter logic [DATA_W-1:0] LFSR_POLY   = DATA_W'(BKP_LFSR_POLY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              loop_i,
  input  logic [1:0]        mode_i,
  input  logic              BkpCfg_Busy_i,
  output logic              BkpCfg_Ready_o,
  output logic [DATA_W-1:0] BkpCfg_DataIndex_o,
  output logic [DATA_W-1:0] BkpCfg_DataValue_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       issued_o
);

  localparam int                CNT_W      = $clog2(GAP);
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(GAP - 1);
  localparam logic [DATA_W-1:0] IDX_LAST   = INDEX_BASE + DATA_W'(INDEX_MAX - 1);

  bkp_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] idx_q, val_q, idx_nxt;
  logic [DATA_W-1:0] lfsr_q, lfsr_nxt;
  logic [1:0]        mode_q;
  logic              loop_q;
  logic [31:0]       issued_q;
  logic              strobe, start_go, last;

  function automatic logic [DATA_W-1:0] map_value(input logic [1:0]        md,
                                                  input logic [DATA_W-1:0] idx,
                                                  input logic [DATA_W-1:0] lf);
    case (md)
      BKP_MODE_IDX:  map_value = idx;
      BKP_MODE_INV:  map_value = ~idx;
      BKP_MODE_LFSR: map_value = lf;
      default:       map_value = CONST_VALUE;
    endcase
  endfunction

  assign start_go = (state == BKP_IDLE) && start_i && !stop_i;
  assign last     = (idx_q == IDX_LAST);
  assign idx_nxt  = (last && loop_q) ? INDEX_BASE : idx_q + DATA_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= BKP_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BKP_IDLE: if (start_i && !stop_i) state_nxt = BKP_RUN;
      BKP_RUN: begin
        if (stop_i)                         state_nxt = BKP_IDLE;
        else if (strobe && last && !loop_q) state_nxt = BKP_DONE;
      end
      BKP_DONE: state_nxt = BKP_IDLE;
      default:  state_nxt = BKP_IDLE;
    endcase
  end

  // Ready depends only on registered state plus downstream back-pressure.
  always_comb begin
    strobe = (state == BKP_RUN) && (cnt == '0) && !BkpCfg_Busy_i;
    busy_o = (state == BKP_RUN);
    done_o = (state == BKP_DONE);
  end

  // The value register always holds the value for the index currently presented,
  // so both are updated together on load and on each strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= CNT_RELOAD;
      idx_q    <= INDEX_BASE;
      val_q    <= '0;
      mode_q   <= BKP_MODE_IDX;
      loop_q   <= 1'b0;
      issued_q <= '0;
    end else if (start_go) begin
      cnt      <= CNT_RELOAD;
      idx_q    <= INDEX_BASE;
      val_q    <= map_value(mode_i, INDEX_BASE, LFSR_SEED);
      mode_q   <= mode_i;
      loop_q   <= loop_i;
      issued_q <= '0;
    end else if (state == BKP_RUN) begin
      if (strobe) begin
        cnt   <= CNT_RELOAD;
        idx_q <= idx_nxt;
        val_q <= map_value(mode_q, idx_nxt, lfsr_nxt);
        if (issued_q != '1) issued_q <= issued_q + 32'd1;
      end else if (!BkpCfg_Busy_i && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  bkp_lfsr #(
    .DATA_W (DATA_W),
    .SEED   (LFSR_SEED),
    .POLY   (LFSR_POLY)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (start_go),
    .adv      (strobe),
    .lfsr_q   (lfsr_q),
    .lfsr_nxt (lfsr_nxt)
  );

  assign BkpCfg_Ready_o     = strobe;
  assign BkpCfg_DataIndex_o = idx_q;
  assign BkpCfg_DataValue_o = val_q;
  assign issued_o           = issued_q;

endmodule

// File: tb/tb_bkp_cfg_gen.sv
// Scoreboard bench for bkp_cfg_gen: expected strobes are queued at start and popped on Ready.
module tb_bkp_cfg_gen;

  localparam int          IMAX  = 5;
  localparam int          GAP   = 4;
  localparam logic [31:0] CVAL  = 32'h5A5A_0F0F;
  localparam logic [31:0] SEED  = 32'hACE1_ACE1;
  localparam logic [31:0] POLY  = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst, start_i, stop_i, loop_i, BkpCfg_Busy_i;
  logic [1:0]  mode_i;
  logic        BkpCfg_Ready_o, busy_o, done_o;
  logic [31:0] BkpCfg_DataIndex_o, BkpCfg_DataValue_o, issued_o;

  typedef struct {
    logic [31:0] idx;
    logic [31:0] val;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t e_m;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;
  int   exp_done = -1;
  bit   done_seen = 1'b0;

  bkp_cfg_gen #(
    .DATA_W      (32),
    .INDEX_MAX   (IMAX),
    .INDEX_BASE  (32'd1),
    .GAP         (GAP),
    .CONST_VALUE (CVAL),
    .LFSR_SEED   (SEED),
    .LFSR_POLY   (POLY)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start_i            (start_i),
    .stop_i             (stop_i),
    .loop_i             (loop_i),
    .mode_i             (mode_i),
    .BkpCfg_Busy_i      (BkpCfg_Busy_i),
    .BkpCfg_Ready_o     (BkpCfg_Ready_o),
    .BkpCfg_DataIndex_o (BkpCfg_DataIndex_o),
    .BkpCfg_DataValue_o (BkpCfg_DataValue_o),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .issued_o           (issued_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    lfsr_step = x >> 1;
    if (x[0]) lfsr_step = lfsr_step ^ POLY;
  endfunction

  function automatic logic [31:0] model_val(input logic [1:0] md, input logic [31:0] idx,
                                            input logic [31:0] lf);
    case (md)
      2'd0:    model_val = idx;
      2'd1:    model_val = ~idx;
      2'd2:    model_val = lf;
      default: model_val = CVAL;
    endcase
  endfunction

  always @(negedge clk) begin
    if (BkpCfg_Ready_o) begin
      if (sb.size() == 0) begin
        chk("unexp_strobe", 64'd1, 64'd0);
      end else begin
        e_m = sb.pop_front();
        chk("strobe_idx", BkpCfg_DataIndex_o, e_m.idx);
        chk("strobe_val", BkpCfg_DataValue_o, e_m.val);
        chk("strobe_at", cyc, e_m.at);
      end
    end
    if (done_o) begin
      chk("done_at", cyc, exp_done);
      chk("busy_in_done", busy_o, 1'b0);
      done_seen = 1'b1;
    end
  end

  // kill: 0 none, 1 stop_i, 2 rst -- asserted one cycle after the last expected strobe.
  task automatic run(input logic [1:0] md, input logic lp, input int n, input int b0,
                     input int b1, input int kill, input bit poke_start);
    int          c, t, tl, idx_m;
    logic [31:0] lf;
    exp_t        e;
    @(posedge clk); #1;
    c = cyc;
    lf = SEED; idx_m = 1; t = c;
    for (int k = 0; k < n; k++) begin
      t = t + GAP;
      while (t >= c + b0 && t <= c + b1) t++;
      e.idx = idx_m; e.val = model_val(md, idx_m, lf); e.at = t;
      sb.push_back(e);
      idx_m = (idx_m == IMAX) ? 1 : idx_m + 1;
      lf = lfsr_step(lf);
    end
    tl = t;
    exp_done = (kill == 0 && !lp) ? tl + 1 : -1;
    done_seen = 1'b0;
    start_i = 1'b1; mode_i = md; loop_i = lp;
    for (int cy = 0; cy < tl + 2 * GAP - c; cy++) begin
      @(posedge clk); #1;
      start_i       = poke_start && (cyc == c + 6);
      BkpCfg_Busy_i = (cyc >= c + b0) && (cyc <= c + b1);
      stop_i        = (kill == 1) && (cyc == tl + 1);
      rst           = (kill == 2) && (cyc == tl + 1);
      if (cyc == c + 1) chk("busy_run", busy_o, 1'b1);
      if (kill == 1 && cyc == tl + 2) begin
        chk("stop_busy", busy_o, 1'b0);
        chk("stop_issued", issued_o, n);
      end
      if (kill == 2 && cyc == tl + 2) begin
        chk("rst_ready", BkpCfg_Ready_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_index", BkpCfg_DataIndex_o, 32'd1);
        chk("rst_value", BkpCfg_DataValue_o, 32'd0);
        chk("rst_issued", issued_o, 32'd0);
      end
    end
    start_i = 1'b0; stop_i = 1'b0; rst = 1'b0; BkpCfg_Busy_i = 1'b0;
    chk("sb_left", sb.size(), 0);
    chk("busy_end", busy_o, 1'b0);
    chk("done_seen", done_seen, exp_done >= 0);
    chk("issued_end", issued_o, (kill == 2) ? 0 : n);
    sb.delete();
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; loop_i = 1'b0;
    mode_i = 2'd0; BkpCfg_Busy_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", BkpCfg_Ready_o, 1'b0);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_done", done_o, 1'b0);
    chk("reset_issued", issued_o, 32'd0);
    chk("reset_index", BkpCfg_DataIndex_o, 32'd1);
    chk("reset_value", BkpCfg_DataValue_o, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run(2'd0, 1'b0, 5, -1, -1, 0, 1'b1);  // plain pass, start pulsed mid-run
    run(2'd0, 1'b0, 5,  8, 10, 0, 1'b0);  // back-pressure on the second strobe
    run(2'd1, 1'b1, 7, -1, -1, 1, 1'b0);  // loop with wrap, then stop
    run(2'd2, 1'b0, 5, -1, -1, 0, 1'b0);  // LFSR values
    run(2'd0, 1'b0, 2, -1, -1, 2, 1'b0);  // reset mid-run
    run(2'd3, 1'b0, 5, -1, -1, 0, 1'b0);  // restart from index 1, constant values

    @(posedge clk); #1;
    start_i = 1'b1; stop_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; stop_i = 1'b0;
    chk("startstop_busy", busy_o, 1'b0);
    repeat (GAP + 2) @(posedge clk);
    #1;
    chk("startstop_busy_late", busy_o, 1'b0);
    chk("startstop_issued", issued_o, 32'd5);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
